// File: rtl/extint_chk_pkg.sv
// Shared types and field map for the extint result checker.
// The field map describes the LSB-first layout of the extint result vector; field 24 is padding.
package extint_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int         FIELD_CNT  = 25;
    localparam logic [4:0] FIELD_NONE = 5'd31;

    localparam int FIELD_LSB [FIELD_CNT] = '{
         0,  4,  8, 12, 16, 20, 24, 28,
        32, 34, 36, 38, 40, 43, 46, 49,
        52, 54, 56, 58, 60, 63, 66, 69,
        72
    };

    localparam int FIELD_W [FIELD_CNT] = '{
         4,  4,  4,  4,  4,  4,  4,  4,
         2,  2,  2,  2,  3,  3,  3,  3,
         2,  2,  2,  2,  3,  3,  3,  3,
        56
    };

endpackage

// File: rtl/extint_field_decode.sv
// Priority encoder: lowest field index whose diff bits are nonzero, FIELD_NONE if none.
// Purely combinational; no handshake.
module extint_field_decode #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] diff,
    output logic [4:0]       field_idx
);
    import extint_chk_pkg::*;

    function automatic logic [WIDTH-1:0] field_mask(input int idx);
        logic [WIDTH-1:0] ones;
        ones = '1;
        return (ones >> (WIDTH - FIELD_W[idx])) << FIELD_LSB[idx];
    endfunction

    // Scan from the top down so the lowest matching field is the one left standing.
    always_comb begin
        field_idx = FIELD_NONE;
        for (int i = FIELD_CNT - 1; i >= 0; i--) begin
            if (|(diff & field_mask(i))) begin
                field_idx = 5'(i);
            end
        end
    end

endmodule

// File: rtl/extint_result_checker.sv
// Masked compare of DUT vs expected extint results with counters and first-error capture.
// Latency: counters reflect a beat 2 cycles after acceptance. Backpressure: in_ready only in RUN.
// Field decode of the first error is built only when EXTINT_CHK_FIELD_MAP_EN is defined.
module extint_result_checker #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dut_vec,
    input  logic [WIDTH-1:0] exp_vec,
    input  logic [WIDTH-1:0] care_mask,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_diff,
    output logic [4:0]       first_err_field
);
    import extint_chk_pkg::*;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] num_vec_q, num_vec_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] ferr_idx_q, ferr_idx_d;
    logic [WIDTH-1:0] ferr_diff_q, ferr_diff_d;
    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] s1_diff_q, s1_diff_d;
    logic [CNT_W-1:0] s1_idx_q, s1_idx_d;

    logic accept;
    logic run_start;
    logic s1_err;
    logic cap_first;

    assign accept    = (state_q == ST_RUN) && in_valid;
    assign run_start = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign s1_err    = s1_vld_q && (|s1_diff_q);
    // err_cnt_q only leaves zero on an error and never wraps back, so zero means "no error yet".
    assign cap_first = s1_err && (err_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        num_vec_d   = num_vec_q;
        acc_cnt_d   = acc_cnt_q;
        vec_cnt_d   = vec_cnt_q;
        err_cnt_d   = err_cnt_q;
        ferr_idx_d  = ferr_idx_q;
        ferr_diff_d = ferr_diff_q;
        s1_vld_d    = accept;
        s1_diff_d   = s1_diff_q;
        s1_idx_d    = s1_idx_q;

        if (accept) begin
            s1_diff_d = (dut_vec ^ exp_vec) & care_mask;
            s1_idx_d  = acc_cnt_q;
        end

        if (s1_vld_q) begin
            vec_cnt_d = vec_cnt_q + 1'b1;
            if (s1_err && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (cap_first) begin
                ferr_idx_d  = s1_idx_q;
                ferr_diff_d = s1_diff_q;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    num_vec_d   = num_vec;
                    acc_cnt_d   = '0;
                    vec_cnt_d   = '0;
                    err_cnt_d   = '0;
                    ferr_idx_d  = '0;
                    ferr_diff_d = '0;
                    state_d     = (num_vec == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    acc_cnt_d = acc_cnt_q + 1'b1;
                    if (acc_cnt_d == num_vec_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // S2 is the counter bank itself, so an empty S1 after this edge means fully drained.
                if (!s1_vld_d) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            num_vec_q   <= '0;
            acc_cnt_q   <= '0;
            vec_cnt_q   <= '0;
            err_cnt_q   <= '0;
            ferr_idx_q  <= '0;
            ferr_diff_q <= '0;
            s1_vld_q    <= 1'b0;
            s1_diff_q   <= '0;
            s1_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            num_vec_q   <= num_vec_d;
            acc_cnt_q   <= acc_cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ferr_idx_q  <= ferr_idx_d;
            ferr_diff_q <= ferr_diff_d;
            s1_vld_q    <= s1_vld_d;
            s1_diff_q   <= s1_diff_d;
            s1_idx_q    <= s1_idx_d;
        end
    end

`ifdef EXTINT_CHK_FIELD_MAP_EN
    logic [4:0] ferr_field_q, ferr_field_d;
    logic [4:0] s1_field;

    extint_field_decode #(
        .WIDTH (WIDTH)
    ) u_field_decode (
        .diff      (s1_diff_q),
        .field_idx (s1_field)
    );

    always_comb begin
        ferr_field_d = ferr_field_q;
        if (cap_first) begin
            ferr_field_d = s1_field;
        end
        if (run_start) begin
            ferr_field_d = FIELD_NONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_field_q <= FIELD_NONE;
        end else begin
            ferr_field_q <= ferr_field_d;
        end
    end

    assign first_err_field = ferr_field_q;
`else
    assign first_err_field = FIELD_NONE;
`endif

    assign in_ready       = (state_q == ST_RUN);
    assign busy           = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (err_cnt_q == '0);
    assign vec_count      = vec_cnt_q;
    assign err_count      = err_cnt_q;
    assign first_err_idx  = ferr_idx_q;
    assign first_err_diff = ferr_diff_q;

endmodule

// File: tb/tb_extint_result_checker.sv
// Directed, table-driven bench for extint_result_checker (default 128-bit / 16-bit counters).
module tb_extint_result_checker;

    localparam int WIDTH = 128;
    localparam int CNT_W = 16;

`ifdef EXTINT_CHK_FIELD_MAP_EN
    localparam int EXP_F8  = 8;
    localparam int EXP_F12 = 12;
`else
    localparam int EXP_F8  = 31;
    localparam int EXP_F12 = 31;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] num_vec;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dut_vec, exp_vec, care_mask;
    logic             busy, done, pass;
    logic [CNT_W-1:0] vec_count, err_count, first_err_idx;
    logic [WIDTH-1:0] first_err_diff;
    logic [4:0]       first_err_field;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    extint_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .num_vec         (num_vec),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .dut_vec         (dut_vec),
        .exp_vec         (exp_vec),
        .care_mask       (care_mask),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .vec_count       (vec_count),
        .err_count       (err_count),
        .first_err_idx   (first_err_idx),
        .first_err_diff  (first_err_diff),
        .first_err_field (first_err_field)
    );

    typedef struct {
        logic [WIDTH-1:0] dut;
        logic [WIDTH-1:0] expv;
        logic [WIDTH-1:0] care;
        int               gap;
        int               cum_err;
        int               ferr_idx;
    } vec_t;

    localparam logic [WIDTH-1:0] BASE = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] B2   = 128'd1 << 2;
    localparam logic [WIDTH-1:0] B33  = 128'd1 << 33;
    localparam logic [WIDTH-1:0] B40  = 128'd1 << 40;
    localparam logic [WIDTH-1:0] B100 = 128'd1 << 100;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        start   = 1'b1;
        num_vec = CNT_W'(n);
        tick();
        start   = 1'b0;
    endtask

    // Returns one cycle after the accepting edge.
    task automatic send_beat(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] e,
                             input logic [WIDTH-1:0] c);
        bit got;
        got       = 1'b0;
        dut_vec   = d;
        exp_vec   = e;
        care_mask = c;
        in_valid  = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            got = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL send_beat_timeout: in_ready never seen, expected within 20 cycles");
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 128'(in_ready), 0);
        chk({tag, "_busy"}, 128'(busy), 0);
        chk({tag, "_done"}, 128'(done), 0);
        chk({tag, "_pass"}, 128'(pass), 0);
        chk({tag, "_vec_count"}, 128'(vec_count), 0);
        chk({tag, "_err_count"}, 128'(err_count), 0);
        chk({tag, "_first_err_idx"}, 128'(first_err_idx), 0);
        chk({tag, "_first_err_diff"}, first_err_diff, 0);
        chk({tag, "_first_err_field"}, 128'(first_err_field), 31);
    endtask

    initial begin
        vec_t tbl [7];
        int   acc;
        logic [5:0] pat;

        tbl[0] = '{dut: BASE,        expv: BASE, care: ONES,          gap: 0, cum_err: 0, ferr_idx: 0};
        tbl[1] = '{dut: BASE ^ B40,  expv: BASE, care: ~B40,          gap: 1, cum_err: 0, ferr_idx: 0};
        tbl[2] = '{dut: BASE ^ B33,  expv: BASE, care: ONES,          gap: 0, cum_err: 1, ferr_idx: 2};
        tbl[3] = '{dut: BASE,        expv: BASE, care: ONES,          gap: 2, cum_err: 1, ferr_idx: 2};
        tbl[4] = '{dut: BASE ^ B2,   expv: BASE, care: ONES,          gap: 0, cum_err: 2, ferr_idx: 2};
        tbl[5] = '{dut: BASE ^ B40,  expv: BASE, care: ONES,          gap: 1, cum_err: 3, ferr_idx: 2};
        tbl[6] = '{dut: BASE ^ B100, expv: BASE, care: ~(ONES << 64), gap: 0, cum_err: 3, ferr_idx: 2};

        rst_n     = 1'b0;
        start     = 1'b0;
        num_vec   = '0;
        in_valid  = 1'b0;
        dut_vec   = '0;
        exp_vec   = '0;
        care_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_reset_vals("rst");

        // Zero-length run
        do_start(0);
        chk("zero_done", 128'(done), 1);
        chk("zero_pass", 128'(pass), 1);
        chk("zero_in_ready", 128'(in_ready), 0);
        chk("zero_vec_count", 128'(vec_count), 0);

        // Clean back-to-back run of 4
        do_start(4);
        dut_vec   = BASE;
        exp_vec   = BASE;
        care_mask = ONES;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("b2b_in_ready", 128'(in_ready), 1);
            tick();
        end
        chk("b2b_rdy_drop", 128'(in_ready), 0);
        chk("b2b_busy_drain", 128'(busy), 1);
        chk("b2b_not_done_yet", 128'(done), 0);
        tick();
        in_valid = 1'b0;
        chk("b2b_done", 128'(done), 1);
        chk("b2b_pass", 128'(pass), 1);
        chk("b2b_vec_count", 128'(vec_count), 4);
        chk("b2b_err_count", 128'(err_count), 0);

        // Masked mismatch, then the same mismatch cared for
        do_start(1);
        send_beat(BASE ^ B40, BASE, ~B40);
        tick();
        chk("mask_off_done", 128'(done), 1);
        chk("mask_off_err", 128'(err_count), 0);
        chk("mask_off_pass", 128'(pass), 1);
        do_start(1);
        send_beat(BASE ^ B40, BASE, ONES);
        tick();
        chk("mask_on_err", 128'(err_count), 1);
        chk("mask_on_pass", 128'(pass), 0);
        chk("mask_on_diff", first_err_diff, B40);
        chk("mask_on_idx", 128'(first_err_idx), 0);
        chk("mask_on_field", 128'(first_err_field), EXP_F12);

        // Table-driven run with gaps and first-error retention
        do_start(7);
        for (int i = 0; i < 7; i++) begin
            repeat (tbl[i].gap) tick();
            send_beat(tbl[i].dut, tbl[i].expv, tbl[i].care);
            chk("tbl_vec_latency", 128'(vec_count), 128'(i));
            tick();
            chk("tbl_vec_count", 128'(vec_count), 128'(i + 1));
            chk("tbl_err_count", 128'(err_count), 128'(tbl[i].cum_err));
            chk("tbl_first_idx", 128'(first_err_idx), 128'(tbl[i].ferr_idx));
        end
        chk("tbl_done", 128'(done), 1);
        chk("tbl_pass", 128'(pass), 0);
        chk("tbl_first_diff", first_err_diff, B33);
        chk("tbl_first_field", 128'(first_err_field), EXP_F8);

        // Stalled run, start pulse during DRAIN, valid while not ready
        do_start(4);
        pat       = 6'b101101;
        acc       = 0;
        dut_vec   = BASE;
        exp_vec   = BASE;
        care_mask = ONES;
        for (int k = 0; k < 6; k++) begin
            in_valid = pat[k];
            if (in_valid && in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("stall_accepts", 128'(acc), 4);
        chk("stall_rdy_drop", 128'(in_ready), 0);
        chk("stall_busy_drain", 128'(busy), 1);
        start   = 1'b1;
        num_vec = 16'd9;
        tick();
        start   = 1'b0;
        chk("stall_done", 128'(done), 1);
        chk("stall_busy", 128'(busy), 0);
        chk("stall_vec_count", 128'(vec_count), 4);
        chk("stall_pass", 128'(pass), 1);
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("idle_valid_no_effect", 128'(vec_count), 4);
        chk("idle_valid_rdy", 128'(in_ready), 0);

        // Asynchronous reset mid-run
        do_start(6);
        send_beat(BASE ^ B2, BASE, ONES);
        send_beat(BASE, BASE, ONES);
        tick();
        chk("pre_rst_err", 128'(err_count), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 128'(busy), 0);
        do_start(1);
        send_beat(BASE, BASE, ONES);
        tick();
        chk("post_rst_done", 128'(done), 1);
        chk("post_rst_pass", 128'(pass), 1);
        chk("post_rst_vec_count", 128'(vec_count), 1);
        chk("post_rst_err_count", 128'(err_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/extint_result_checker.md
Name: extint_result_checker

Overview:
- Downstream consumer of the extint-family 128-bit result vector; sits between the DUT output and the cosim harness scoreboard.
- Accepts a stream of (DUT result, expected result, care mask) beats over a valid/ready handshake and compares them with a masked compare.
- Counts vectors and mismatches, and captures the first failing vector: its index, diff and offending field.
- Reports pass/fail once the programmed number of vectors has been checked.

Parameters:
- WIDTH, 128: result vector width.
- CNT_W, 16: width of the vector and error counters.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a run.
- num_vec  input  CNT_W  number of vectors in a run; sampled on start.
- in_valid  input  1  beat valid.
- in_ready  output  1  checker can accept a beat.
- dut_vec  input  WIDTH  DUT result.
- exp_vec  input  WIDTH  expected result.
- care_mask  input  WIDTH  1 = compare this bit; 0 = don't care (used where the expected value is x/z).
- busy  output  1  high in RUN or DRAIN.
- done  output  1  run complete; level.
- pass  output  1  done and err_count==0.
- vec_count  output  CNT_W  beats checked.
- err_count  output  CNT_W  mismatching beats; saturates at all-ones.
- first_err_idx  output  CNT_W  index of the first failing beat (0-based).
- first_err_diff  output  WIDTH  masked XOR of the first failing beat.
- first_err_field  output  5  lowest failing field index; 31 = none or unavailable.

Behaviour:
- Reset values: in_ready=0, busy=0, done=0, pass=0, all counters 0, first_err_idx=0, first_err_diff=0, first_err_field=31, FSM=IDLE, pipeline valids=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE, start=1: latch num_vec, clear counters and first-error capture. If num_vec==0, go to DONE (pass=1 on the next cycle); otherwise go to RUN.
  - RUN: in_ready=1. A beat is accepted when in_valid&in_ready. When the accepted count equals num_vec, in_ready deasserts the following cycle and the FSM moves to DRAIN.
  - DRAIN: in_ready=0. Move to DONE when both pipeline stages are empty.
  - start is ignored in RUN and DRAIN.
  - done and pass hold in DONE until the next start.
- Pipeline:
  - S1 registers diff = (dut_vec ^ exp_vec) & care_mask, plus the beat index.
  - S2 updates vec_count and err_count, and captures the first error.
  - Counters reflect a beat exactly 2 cycles after acceptance.
- Error rule: a beat is in error iff |diff.
- First-error capture: on the first error of a run, load first_err_idx, first_err_diff and first_err_field. Later errors do not alter them.
- Saturation: err_count sticks at 2^CNT_W-1. vec_count cannot wrap because it is bounded by num_vec.
- Back-to-back: one beat per cycle is sustained, with no bubbles.
- in_valid while in_ready=0 is not accepted, and there is no side effect.
- Asynchronous reset mid-run returns every state to its reset value immediately; in-flight beats are discarded.
- Field map (LSB first, field index: bits):
  - 0-3: 4b each, bits 0-15.
  - 4-7: 4b each, bits 16-31.
  - 8-11: 2b each, bits 32-39.
  - 12-15: 3b each, bits 40-51.
  - 16-19: 2b each, bits 52-59.
  - 20-23: 3b each, bits 60-71.
  - 24: pad, bits 72-127.

Optional Feature:
- Macro: EXTINT_CHK_FIELD_MAP_EN.
- Defined: first_err_field = lowest field index whose bits of diff are nonzero, per the field map, computed in S2.
- Undefined: no field decode logic is built; first_err_field stays 31. All other behaviour is identical.

Decomposition:
- Package extint_chk_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - field count 25;
  - per-field LSB and width constant arrays;
  - FIELD_NONE = 5'd31.
- Sub-module extint_field_decode: purely combinational priority encoder from diff[WIDTH-1:0] to a 5-bit field index. Instantiated only under EXTINT_CHK_FIELD_MAP_EN.

Test Plan:
- Zero-length run: start with num_vec=0 -> done=1 and pass=1 on the second cycle; in_ready is never asserted; vec_count=0.
- Clean run: num_vec=4, four back-to-back beats with dut==exp and care=all-ones -> in_ready high for exactly 4 accepts; done 2 cycles after the last accept; pass=1; vec_count=4; err_count=0.
- Masked mismatch: dut bit 40 differs from exp but care_mask[40]=0 -> no error.
  - Same stimulus with care_mask[40]=1 -> err_count=1, first_err_diff=1<<40, first_err_field=12 (macro on) or 31 (macro off).
- First-error retention: num_vec=5, errors on beats 1 (bit 33) and 3 (bit 2) -> err_count=2, first_err_idx=1, first_err_field=8.
- Backpressure/stall: in_valid toggles 1,0,1,1,0,1 over a num_vec=4 run -> exactly 4 accepts counted; in_ready drops after the 4th accept; a start pulse in DRAIN is ignored.
- Reset mid-run: assert rst_n=0 after 2 of 6 beats -> all outputs return to reset values in the same cycle. A new start with num_vec=1 then completes normally.
